// File: rtl/instr_sequencer.sv
// ============================================================================
// instr_sequencer
// ----------------------------------------------------------------------------
// Multi-cycle issue/control FSM for a small MIPS-style datapath. It accepts
// one 32-bit instruction per valid/ready handshake. It then sequences the
// register-file read, the ALU operation and either a register write-back or a
// beq resolution, and it maintains an 8-bit program counter.
//
// Instruction word layout (field positions are fixed by the decode path):
//   opcode[31:26] rs[23:21] rt[18:16] rd[13:11] funct[5:0] imm[15:0]
//
// Supported encodings:
//   R-type (opcode 000000): funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or,
//                           0x2A slt; the result is written to rd.
//   beq    (opcode 000100): compares rs and rt with the ALU eq operation;
//                           when taken, pc = pc + 1 + imm[PC_W-1:0].
//   addi   (opcode 001000): only when the build macro SEQ_ADDI_EN is defined.
//                           Operand B is imm[ALU_W-1:0] and the result is
//                           written to rt. Without the macro this opcode is
//                           illegal.
//   Any other encoding retires as illegal: done and illegal pulse together
//   and the pc advances by one.
//
// Flow: IDLE -> DECODE -> READ -> EXEC -> (WB | BRANCH) -> IDLE.
// A legal instruction retires (done pulse) 4 cycles after its accept edge.
// An illegal instruction retires 1 cycle after its accept edge. The sequencer
// is back in IDLE with instr_ready high during the done cycle.
//
// Parameters:
//   PC_W    program counter width (pc wraps modulo 2**PC_W, PC_W <= 16)
//   DATA_W  register-file data width (must exceed ALU_W)
//   ALU_W   ALU operand/result width; operands are rf data[ALU_W-1:0]
//
// Ports:
//   clk          in   rising-edge clock for all state
//   reset        in   synchronous active-high reset; aborts any instruction
//   instr_valid  in   instruction word present
//   instr_ready  out  high in IDLE only
//   instr        in   32-bit instruction word
//   rf_ra1/ra2   out  register-file read addresses (rs / rt)
//   rf_rd1/rd2   in   combinational register-file read data
//   rf_we        out  one-cycle write-enable pulse
//   rf_wa/wd     out  write address / write data ({zeros, alu result})
//   alu_a/alu_b  out  ALU operands, held outside READ/EXEC
//   alu_opcode   out  000 add, 001 sub, 010 and, 011 or, 100 slt, 101 eq
//   alu_result   in   ALU result, sampled at the end of EXEC
//   alu_zero     in   ALU zero flag, sampled at the end of EXEC
//   pc           out  current program counter
//   done         out  one-cycle retire pulse
//   illegal      out  one-cycle pulse together with done on a bad encoding
// ============================================================================
module instr_sequencer #(
    parameter int PC_W   = 8,
    parameter int DATA_W = 8,
    parameter int ALU_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    output logic [2:0]        rf_ra1,
    output logic [2:0]        rf_ra2,
    input  logic [DATA_W-1:0] rf_rd1,
    input  logic [DATA_W-1:0] rf_rd2,
    output logic              rf_we,
    output logic [2:0]        rf_wa,
    output logic [DATA_W-1:0] rf_wd,
    output logic [ALU_W-1:0]  alu_a,
    output logic [ALU_W-1:0]  alu_b,
    output logic [2:0]        alu_opcode,
    input  logic [ALU_W-1:0]  alu_result,
    input  logic              alu_zero,
    output logic [PC_W-1:0]   pc,
    output logic              done,
    output logic              illegal
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_READ   = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_BRANCH = 3'd5;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
`ifdef SEQ_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_EQ  = 3'b101;

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------

    // Next sequential pc plus an optional branch offset, modulo 2**PC_W.
    function automatic logic [PC_W-1:0] pc_advance(input logic [PC_W-1:0] pc_cur,
                                                   input logic [PC_W-1:0] offs);
        return pc_cur + offs + {{(PC_W-1){1'b0}}, 1'b1};
    endfunction

    // Zero-extend an ALU result to register-file width.
    function automatic logic [DATA_W-1:0] widen_result(input logic [ALU_W-1:0] r);
        return {{(DATA_W-ALU_W){1'b0}}, r};
    endfunction

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    logic [2:0]        state_q,  state_d;
    logic [31:0]       instr_q,  instr_d;
    logic [2:0]        op_q,     op_d;      // decoded ALU operation
    logic              branch_q, branch_d;  // instruction is beq
    logic              addi_q,   addi_d;    // instruction is addi
    logic [2:0]        ra1_q,    ra1_d;
    logic [2:0]        ra2_q,    ra2_d;
    logic [ALU_W-1:0]  a_q,      a_d;
    logic [ALU_W-1:0]  b_q,      b_d;
    logic [2:0]        aluop_q,  aluop_d;
    logic [ALU_W-1:0]  res_q,    res_d;
    logic              zero_q,   zero_d;
    logic              we_q,     we_d;
    logic [2:0]        wa_q,     wa_d;
    logic [DATA_W-1:0] wd_q,     wd_d;
    logic [PC_W-1:0]   pc_q,     pc_d;
    logic              done_q,   done_d;
    logic              ill_q,    ill_d;

    // ------------------------------------------------------------------------
    // Field extraction from the latched instruction
    // ------------------------------------------------------------------------
    logic [5:0]      f_opcode;
    logic [5:0]      f_funct;
    logic [2:0]      f_rs;
    logic [2:0]      f_rt;
    logic [2:0]      f_rd;
    logic [PC_W-1:0] f_imm_pc;
    logic [ALU_W-1:0] f_imm_alu;

    assign f_opcode  = instr_q[31:26];
    assign f_funct   = instr_q[5:0];
    assign f_rs      = instr_q[23:21];
    assign f_rt      = instr_q[18:16];
    assign f_rd      = instr_q[13:11];
    assign f_imm_pc  = instr_q[PC_W-1:0];
    assign f_imm_alu = instr_q[ALU_W-1:0];

    // Several instruction bits and the upper register-data bits are don't-care
    // for this datapath; fold them here so they are consumed explicitly.
    logic unused_bits;
    assign unused_bits = ^{instr_q, rf_rd1, rf_rd2};

    // ------------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------------
    logic       dec_legal;
    logic       dec_branch;
    logic       dec_addi;
    logic [2:0] dec_op;

    always_comb begin
        dec_legal  = 1'b0;
        dec_branch = 1'b0;
        dec_addi   = 1'b0;
        dec_op     = ALU_ADD;
        case (f_opcode)
            OP_RTYPE: begin
                dec_legal = 1'b1;
                case (f_funct)
                    FN_ADD:  dec_op = ALU_ADD;
                    FN_SUB:  dec_op = ALU_SUB;
                    FN_AND:  dec_op = ALU_AND;
                    FN_OR:   dec_op = ALU_OR;
                    FN_SLT:  dec_op = ALU_SLT;
                    default: dec_legal = 1'b0;
                endcase
            end
            OP_BEQ: begin
                dec_legal  = 1'b1;
                dec_branch = 1'b1;
                dec_op     = ALU_EQ;
            end
`ifdef SEQ_ADDI_EN
            OP_ADDI: begin
                dec_legal = 1'b1;
                dec_addi  = 1'b1;
                dec_op    = ALU_ADD;
            end
`endif
            default: ;
        endcase
    end

    // addi writes rt; R-type writes rd. Register 0 is never written.
    logic [2:0] wr_addr;
    assign wr_addr = addi_q ? f_rt : f_rd;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        op_d     = op_q;
        branch_d = branch_q;
        addi_d   = addi_q;
        ra1_d    = ra1_q;
        ra2_d    = ra2_q;
        a_d      = a_q;
        b_d      = b_q;
        aluop_d  = aluop_q;
        res_d    = res_q;
        zero_d   = zero_q;
        we_d     = 1'b0;
        wa_d     = wa_q;
        wd_d     = wd_q;
        pc_d     = pc_q;
        done_d   = 1'b0;
        ill_d    = 1'b0;

        case (state_q)
            // Wait for a handshake; latch the whole word.
            S_IDLE: begin
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = S_DECODE;
                end
            end

            // Classify; present read addresses for READ, or retire illegal.
            S_DECODE: begin
                if (dec_legal) begin
                    op_d     = dec_op;
                    branch_d = dec_branch;
                    addi_d   = dec_addi;
                    ra1_d    = f_rs;
                    ra2_d    = f_rt;
                    state_d  = S_READ;
                end else begin
                    done_d  = 1'b1;
                    ill_d   = 1'b1;
                    pc_d    = pc_advance(pc_q, '0);
                    state_d = S_IDLE;
                end
            end

            // Register-file data is combinational; capture ALU operands.
            S_READ: begin
                a_d     = rf_rd1[ALU_W-1:0];
                b_d     = addi_q ? f_imm_alu : rf_rd2[ALU_W-1:0];
                aluop_d = op_q;
                state_d = S_EXEC;
            end

            // ALU is combinational on the held operands; capture its outputs.
            S_EXEC: begin
                res_d   = alu_result;
                zero_d  = alu_zero;
                state_d = branch_q ? S_BRANCH : S_WB;
            end

            S_WB: begin
                if (wr_addr != 3'd0) begin
                    we_d = 1'b1;
                    wa_d = wr_addr;
                    wd_d = widen_result(res_q);
                end
                done_d  = 1'b1;
                pc_d    = pc_advance(pc_q, '0);
                state_d = S_IDLE;
            end

            S_BRANCH: begin
                done_d  = 1'b1;
                pc_d    = pc_advance(pc_q, zero_q ? f_imm_pc : '0);
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers; reset clears everything so a mid-instruction reset leaves
    // no write, no pc update and no retire pulse.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            instr_q  <= '0;
            op_q     <= ALU_ADD;
            branch_q <= 1'b0;
            addi_q   <= 1'b0;
            ra1_q    <= '0;
            ra2_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluop_q  <= ALU_ADD;
            res_q    <= '0;
            zero_q   <= 1'b0;
            we_q     <= 1'b0;
            wa_q     <= '0;
            wd_q     <= '0;
            pc_q     <= '0;
            done_q   <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            op_q     <= op_d;
            branch_q <= branch_d;
            addi_q   <= addi_d;
            ra1_q    <= ra1_d;
            ra2_q    <= ra2_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aluop_q  <= aluop_d;
            res_q    <= res_d;
            zero_q   <= zero_d;
            we_q     <= we_d;
            wa_q     <= wa_d;
            wd_q     <= wd_d;
            pc_q     <= pc_d;
            done_q   <= done_d;
            ill_q    <= ill_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign instr_ready = (state_q == S_IDLE);
    assign rf_ra1      = ra1_q;
    assign rf_ra2      = ra2_q;
    assign rf_we       = we_q;
    assign rf_wa       = wa_q;
    assign rf_wd       = wd_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_opcode  = aluop_q;
    assign pc          = pc_q;
    assign done        = done_q;
    assign illegal     = ill_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: a small register file and ALU surround the DUT.
// Each issued instruction gets an expected retire record computed from the
// instruction-set rules; a monitor compares every done pulse with the oldest
// record in the queue.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [2:0]  rf_ra1, rf_ra2, rf_wa;
    logic [7:0]  rf_rd1, rf_rd2, rf_wd;
    logic        rf_we;
    logic [3:0]  alu_a, alu_b, alu_result;
    logic [2:0]  alu_opcode;
    logic        alu_zero;
    logic [7:0]  pc;
    logic        done, illegal;

    always #5 clk = ~clk;

    instr_sequencer dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .alu_a(alu_a), .alu_b(alu_b),
        .alu_opcode(alu_opcode), .alu_result(alu_result), .alu_zero(alu_zero),
        .pc(pc), .done(done), .illegal(illegal)
    );

    // Environment register file: combinational reads, writes on clock edge.
    logic [7:0] env_rf [8];
    logic       pre_en = 1'b0;
    logic [2:0] pre_a  = '0;
    logic [7:0] pre_d  = '0;
    assign rf_rd1 = env_rf[rf_ra1];
    assign rf_rd2 = env_rf[rf_ra2];
    always @(posedge clk) begin
        if (rf_we)  env_rf[rf_wa] <= rf_wd;
        if (pre_en) env_rf[pre_a] <= pre_d;
    end

    // Environment ALU.
    always_comb begin
        case (alu_opcode)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a - alu_b;
            3'b010:  alu_result = alu_a & alu_b;
            3'b011:  alu_result = alu_a | alu_b;
            3'b100:  alu_result = ($signed(alu_a) < $signed(alu_b)) ? 4'd1 : 4'd0;
            3'b101:  alu_result = (alu_a == alu_b) ? 4'd0 : 4'd1;
            default: alu_result = 4'd0;
        endcase
    end
    assign alu_zero = (alu_result == 4'd0);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0h, required %0h", nm, act, req);
    endtask

    // Reference model state and expected retire record.
    typedef struct packed {
        logic       ill;
        logic       we;
        logic [2:0] wa;
        logic [7:0] wd;
        logic [7:0] pc;
        int         due;
    } exp_t;

    exp_t       sbq[$];
    string      nmq[$];
    logic [7:0] m_rf [8];
    logic [7:0] m_pc = '0;

    function automatic exp_t predict(input logic [31:0] w);
        exp_t e;
        int a, b, res, dest, sa, sb;
        bit alu_ins;
        logic [5:0] op, fn;
        op   = w[31:26];
        fn   = w[5:0];
        a    = int'(m_rf[w[23:21]]) % 16;
        b    = int'(m_rf[w[18:16]]) % 16;
        dest = int'(w[13:11]);
        res  = 0;
        alu_ins = 1'b0;
        e.ill = 1'b1; e.we = 1'b0; e.wa = '0; e.wd = '0;
        e.pc  = m_pc + 8'd1;
        e.due = 1;
        if (op == 6'h00) begin
            alu_ins = 1'b1;
            case (fn)
                6'h20: res = (a + b) % 16;
                6'h22: res = (a - b + 16) % 16;
                6'h24: res = a & b;
                6'h25: res = a | b;
                6'h2A: begin
                    sa  = (a >= 8) ? a - 16 : a;
                    sb  = (b >= 8) ? b - 16 : b;
                    res = (sa < sb) ? 1 : 0;
                end
                default: alu_ins = 1'b0;
            endcase
        end
`ifdef SEQ_ADDI_EN
        if (op == 6'h08) begin
            alu_ins = 1'b1;
            res  = (a + int'(w[3:0])) % 16;
            dest = int'(w[18:16]);
        end
`endif
        if (alu_ins) begin
            e.ill = 1'b0; e.due = 4;
            e.we  = (dest != 0);
            e.wa  = 3'(dest);
            e.wd  = 8'(res);
        end
        if (op == 6'h04) begin
            e.ill = 1'b0; e.due = 4;
            if (a == b) e.pc = m_pc + 8'd1 + w[7:0];
        end
        return e;
    endfunction

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'b0, 2'b0, 3'(rs), 2'b0, 3'(rt), 2'b0, 3'(rd), 5'b0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 2'b0, 3'(rs), 2'b0, 3'(rt), imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_reg(input int r, input logic [7:0] v);
        pre_en = 1'b1; pre_a = 3'(r); pre_d = v;
        tick();
        pre_en = 1'b0;
        m_rf[r] = v;
    endtask

    // Issue one instruction; tracked ones get a scoreboard entry.
    task automatic issue(input logic [31:0] w, input string nm, input bit track);
        int   n;
        exp_t e;
        n = 0;
        while (!instr_ready && n < 60) begin tick(); n++; end
        if (!instr_ready) begin
            chk({nm, "_ready_timeout"}, 0, 1);
            return;
        end
        instr_valid = 1'b1;
        instr       = w;
        tick();
        instr_valid = 1'b0;
        instr       = $urandom;
        if (track) begin
            e = predict(w);
            e.due = cyc + e.due;
            sbq.push_back(e);
            nmq.push_back(nm);
            m_pc = e.pc;
            if (e.we) m_rf[e.wa] = e.wd;
        end
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 100) begin tick(); n++; end
        if (sbq.size() != 0) chk({nm, "_drain_timeout"}, longint'(sbq.size()), 0);
    endtask

    // Monitor: compare every retire with the oldest expectation.
    always @(negedge clk) begin
        exp_t  e;
        string nm;
        if (!reset) begin
            if (done) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e  = sbq.pop_front();
                    nm = nmq.pop_front();
                    chk({nm, "_latency"}, cyc, e.due);
                    chk({nm, "_illegal"}, illegal, e.ill);
                    chk({nm, "_we"}, rf_we, e.we);
                    if (e.we) begin
                        chk({nm, "_wa"}, rf_wa, e.wa);
                        chk({nm, "_wd"}, rf_wd, e.wd);
                    end
                    chk({nm, "_pc"}, pc, e.pc);
                end
            end else begin
                if (rf_we)   chk("we_without_done", 1, 0);
                if (illegal) chk("illegal_without_done", 1, 0);
                if (sbq.size() != 0 && cyc > sbq[0].due + 2) begin
                    chk({nmq[0], "_retire_timeout"}, cyc, sbq[0].due);
                    void'(sbq.pop_front());
                    void'(nmq.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got %0d cycles, required completion", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  r4_before, r6_before;
        logic [31:0] w;
        logic [5:0]  fn;
        bit          any_we;
        int          kind, rs, rt, rd;
        logic [5:0]  fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

        reset = 1'b1; instr_valid = 1'b0; instr = '0;
        for (int i = 0; i < 8; i++) m_rf[i] = '0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset and idle.
        any_we = 1'b0;
        for (int i = 0; i < 4; i++) begin any_we |= rf_we; tick(); end
        chk("rst_pc", pc, 8'h00);
        chk("rst_ready", instr_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_no_we", any_we, 0);

        for (int i = 0; i < 8; i++) set_reg(i, (i == 0) ? 8'h00 : 8'($urandom));
        set_reg(2, 8'd5);
        set_reg(3, 8'd2);

        // sub r1,r2,r3 -> r1=3
        issue(rtype(2, 3, 1, 6'h22), "sub_r1", 1'b1);
        drain("sub_r1");
        chk("sub_pc_const", pc, 8'd1);
        chk("sub_r1_const", env_rf[1], 8'd3);

        // beq not taken, then taken
        issue(itype(6'h04, 1, 2, 16'd4), "beq_nt", 1'b1);
        drain("beq_nt");
        chk("beq_nt_pc_const", pc, 8'd2);
        issue(itype(6'h04, 2, 2, 16'd4), "beq_t", 1'b1);
        drain("beq_t");
        chk("beq_t_pc_const", pc, 8'd7);

        // write to r0 suppressed, illegal opcode
        issue(rtype(2, 3, 0, 6'h20), "add_r0", 1'b1);
        drain("add_r0");
        chk("add_r0_pc_const", pc, 8'd8);
        chk("add_r0_const", env_rf[0], 8'd0);
        issue(32'hFC00_0000, "op3f", 1'b1);
        drain("op3f");
        chk("op3f_pc_const", pc, 8'd9);

        // addi r4,r2,3
        r4_before = env_rf[4];
        issue(itype(6'h08, 2, 4, 16'd3), "addi", 1'b1);
        drain("addi");
        chk("addi_pc_const", pc, 8'd10);
`ifdef SEQ_ADDI_EN
        chk("addi_r4_const", env_rf[4], 8'd8);
`else
        chk("addi_r4_const", env_rf[4], r4_before);
`endif

        // jump to 0xFF, then wrap
        issue(itype(6'h04, 0, 0, 16'hAB00 | 16'd244), "jmp_ff", 1'b1);
        drain("jmp_ff");
        chk("jmp_ff_pc_const", pc, 8'hFF);
        issue(rtype(2, 3, 5, 6'h20), "add_wrap", 1'b1);
        drain("add_wrap");
        chk("wrap_pc_const", pc, 8'h00);
        chk("wrap_r5_const", env_rf[5], 8'd7);

        // reset while in EXEC aborts the instruction
        r6_before = env_rf[6];
        issue(rtype(2, 3, 6, 6'h20), "abort", 1'b0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_pc = 8'h00;
        repeat (4) tick();
        chk("abort_pc", pc, 8'h00);
        chk("abort_ready", instr_ready, 1);
        chk("abort_no_write", env_rf[6], r6_before);

        // randomized traffic
        for (int k = 0; k < 300; k++) begin
            kind = $urandom_range(0, 7);
            rs = $urandom_range(0, 7); rt = $urandom_range(0, 7); rd = $urandom_range(0, 7);
            case (kind)
                0, 1, 2, 3: w = rtype(rs, rt, rd, fns[$urandom_range(0, 4)]) | ($urandom & 32'h0318_07C0);
                4: begin
                    fn = 6'($urandom_range(0, 63));
                    while (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A)
                        fn = 6'($urandom_range(0, 63));
                    w = rtype(rs, rt, rd, fn);
                end
                5: w = itype(6'h04, rs, ($urandom_range(0, 3) == 0) ? rs : rt, 16'($urandom));
                6: w = itype(6'h08, rs, rt, 16'($urandom));
                default: w = $urandom;
            endcase
            issue(w, $sformatf("rnd%0d", k), 1'b1);
            repeat ($urandom_range(0, 2)) tick();
        end
        drain("final");
        chk("final_pc", pc, m_pc);
        for (int i = 1; i < 8; i++) chk($sformatf("final_r%0d", i), env_rf[i], m_rf[i]);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
